// File: rtl/medac_sync_tuner.sv
// medac_sync_tuner: closed-loop sync_sel/win_sel controller for one MEDAC
// synchronizer direction; calibrates win_sel by sweep, adapts sync_sel.
//
// Ports:
//   i_clk        destination-domain clock
//   i_rst        synchronous reset, active-high
//   i_en         adaptive monitoring enable (level)
//   i_cal_start  one-cycle pulse, starts the win_sel calibration sweep
//   i_error_in   error pulse from meta_detector_bits (registered once here)
//   o_sync_sel   synchronizer depth select
//   o_win_sel    shadow-clock delay select
//   o_err_cnt    error count of the last completed window
//   o_cal_busy   calibration sweep in progress
//   o_cal_done   one-cycle pulse when the calibration result is applied
//   o_alarm      sticky: noisy at max depth, or no usable win_sel found
module medac_sync_tuner #(
    parameter int WINDOW        = 256,
    parameter int CNT_W         = 8,
    parameter int ERR_THR       = 2,
    parameter int QUIET_WINDOWS = 16,
    parameter int SETTLE_CYC    = 8,
    parameter int SYNC_INIT     = 1,
    parameter int SYNC_MIN      = 1,
    parameter int WIN_INIT      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_cal_start,
    input  logic             i_error_in,
    output logic [2:0]       o_sync_sel,
    output logic [3:0]       o_win_sel,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic             o_cal_busy,
    output logic             o_cal_done,
    output logic             o_alarm
);

    localparam int TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
    localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
    localparam int Q_W     = $clog2(QUIET_WINDOWS + 1);

    localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] THR      = CNT_W'(ERR_THR);
    localparam logic [Q_W-1:0]   Q_LIM    = Q_W'(QUIET_WINDOWS);
    localparam logic [2:0]       S_MIN    = 3'(SYNC_MIN);
    localparam logic [2:0]       S_INIT   = 3'(SYNC_INIT);
    localparam logic [3:0]       W_INIT   = 4'(WIN_INIT);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SETTLE     = 3'd1;
    localparam logic [2:0] S_MONITOR    = 3'd2;
    localparam logic [2:0] S_EVAL       = 3'd3;
    localparam logic [2:0] S_CAL_SETTLE = 3'd4;
    localparam logic [2:0] S_CAL_OBS    = 3'd5;
    localparam logic [2:0] S_CAL_EVAL   = 3'd6;

    logic [2:0]       r_state;
    logic [TMR_W-1:0] r_tmr;
    logic [CNT_W-1:0] r_cnt;
    logic [Q_W-1:0]   r_quiet;
    logic [3:0]       r_best;
    logic             r_found;
    logic             r_err_q;
    logic [2:0]       r_sync_sel;
    logic [3:0]       r_win_sel;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_cal_busy;
    logic             r_cal_done;
    logic             r_alarm;

    logic [CNT_W-1:0] w_cnt_inc;
    logic [Q_W-1:0]   w_quiet_inc;
    logic             w_noisy;
    logic             w_mon;
    logic             w_cal_go;

    // Saturating window count of the registered error.
    assign w_cnt_inc   = (r_err_q && (r_cnt != {CNT_W{1'b1}}))
                         ? r_cnt + CNT_W'(1) : r_cnt;
    assign w_quiet_inc = (r_quiet == Q_LIM) ? r_quiet : r_quiet + Q_W'(1);
    assign w_noisy     = (r_cnt > THR);
    assign w_mon       = (r_state == S_SETTLE) || (r_state == S_MONITOR) ||
                         (r_state == S_EVAL);
    assign w_cal_go    = i_cal_start && !r_cal_busy &&
                         (w_mon || (r_state == S_IDLE));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_tmr      <= '0;
            r_cnt      <= '0;
            r_quiet    <= '0;
            r_best     <= '0;
            r_found    <= 1'b0;
            r_err_q    <= 1'b0;
            r_sync_sel <= S_INIT;
            r_win_sel  <= W_INIT;
            r_err_cnt  <= '0;
            r_cal_busy <= 1'b0;
            r_cal_done <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_err_q    <= i_error_in;
            r_cal_done <= 1'b0;
            if (w_cal_go) begin
                // Calibration pre-empts monitoring and starts from win_sel 0.
                r_state    <= S_CAL_SETTLE;
                r_tmr      <= '0;
                r_cnt      <= '0;
                r_best     <= '0;
                r_found    <= 1'b0;
                r_win_sel  <= 4'd0;
                r_cal_busy <= 1'b1;
                r_alarm    <= 1'b0;
            end else if (w_mon && !i_en) begin
                // Partial window is discarded.
                r_state <= S_IDLE;
                r_tmr   <= '0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_en) begin
                            r_state <= S_SETTLE;
                            r_tmr   <= '0;
                        end
                    end
                    S_SETTLE: begin
                        r_cnt <= '0;
                        if (r_tmr == SET_LAST) begin
                            r_state <= S_MONITOR;
                            r_tmr   <= '0;
                        end else begin
                            r_tmr <= r_tmr + TMR_W'(1);
                        end
                    end
                    S_MONITOR: begin
                        r_cnt <= w_cnt_inc;
                        if (r_tmr == WIN_LAST) begin
                            r_state <= S_EVAL;
                            r_tmr   <= '0;
                        end else begin
                            r_tmr <= r_tmr + TMR_W'(1);
                        end
                    end
                    S_EVAL: begin
                        r_err_cnt <= r_cnt;
                        r_cnt     <= '0;
                        r_tmr     <= '0;
                        r_state   <= S_MONITOR;
                        if (w_noisy) begin
                            r_quiet <= '0;
                            if (r_sync_sel != 3'd7) begin
                                r_sync_sel <= r_sync_sel + 3'd1;
                                r_state    <= S_SETTLE;
                            end else begin
                                r_alarm <= 1'b1;
                            end
                        end else if (r_cnt == '0) begin
                            if ((w_quiet_inc == Q_LIM) &&
                                (r_sync_sel > S_MIN)) begin
                                r_sync_sel <= r_sync_sel - 3'd1;
                                r_quiet    <= '0;
                                r_state    <= S_SETTLE;
                            end else begin
                                r_quiet <= w_quiet_inc;
                            end
                        end else begin
                            r_quiet <= '0;
                        end
                    end
                    S_CAL_SETTLE: begin
                        r_cnt <= '0;
                        if (r_tmr == SET_LAST) begin
                            r_state <= S_CAL_OBS;
                            r_tmr   <= '0;
                        end else begin
                            r_tmr <= r_tmr + TMR_W'(1);
                        end
                    end
                    S_CAL_OBS: begin
                        r_cnt <= w_cnt_inc;
                        if (r_tmr == WIN_LAST) begin
                            r_state <= S_CAL_EVAL;
                            r_tmr   <= '0;
                        end else begin
                            r_tmr <= r_tmr + TMR_W'(1);
                        end
                    end
                    S_CAL_EVAL: begin
                        r_err_cnt <= r_cnt;
                        r_cnt     <= '0;
                        r_tmr     <= '0;
                        if (!w_noisy) begin
                            r_best  <= r_win_sel;
                            r_found <= 1'b1;
                        end
                        if (r_win_sel == 4'd15) begin
                            // Sweep ascends, so the last qualifier is the largest.
                            if (!w_noisy) begin
                                r_win_sel <= r_win_sel;
                            end else if (r_found) begin
                                r_win_sel <= r_best;
                            end else begin
                                r_win_sel <= 4'd0;
                                r_alarm   <= 1'b1;
                            end
                            r_cal_done <= 1'b1;
                            r_cal_busy <= 1'b0;
                            r_state    <= i_en ? S_SETTLE : S_IDLE;
                        end else begin
                            r_win_sel <= r_win_sel + 4'd1;
                            r_state   <= S_CAL_SETTLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_sync_sel = r_sync_sel;
    assign o_win_sel  = r_win_sel;
    assign o_err_cnt  = r_err_cnt;
    assign o_cal_busy = r_cal_busy;
    assign o_cal_done = r_cal_done;
    assign o_alarm    = r_alarm;

endmodule

// File: tb/tb_medac_sync_tuner.sv
// tb_medac_sync_tuner: directed bench for medac_sync_tuner
// (WINDOW=16, ERR_THR=2, QUIET_WINDOWS=4, SETTLE_CYC=4).
module tb_medac_sync_tuner;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cal_start;
    logic             error_in;
    logic [2:0]       sync_sel;
    logic [3:0]       win_sel;
    logic [CNT_W-1:0] err_cnt;
    logic             cal_busy;
    logic             cal_done;
    logic             alarm;

    int n_chk = 0;
    int n_err = 0;

    medac_sync_tuner #(
        .WINDOW       (16),
        .CNT_W        (CNT_W),
        .ERR_THR      (2),
        .QUIET_WINDOWS(4),
        .SETTLE_CYC   (4),
        .SYNC_INIT    (1),
        .SYNC_MIN     (1),
        .WIN_INIT     (8)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_cal_start(cal_start),
        .i_error_in (error_in),
        .o_sync_sel (sync_sel),
        .o_win_sel  (win_sel),
        .o_err_cnt  (err_cnt),
        .o_cal_busy (cal_busy),
        .o_cal_done (cal_done),
        .o_alarm    (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive error_in for one cycle, then sample 1 ns after the edge.
    task automatic cyc(input logic e);
        error_in = e;
        @(posedge clk);
        #1;
    endtask

    int done_cnt;
    int done_at;
    int busy_fall;
    int guard;

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        cal_start = 1'b0;
        error_in  = 1'b0;

        // 1: reset state
        repeat (3) cyc(1'b0);
        check("rst_sync", 32'(sync_sel), 1);
        check("rst_win", 32'(win_sel), 8);
        check("rst_errcnt", 32'(err_cnt), 0);
        check("rst_busy", 32'(cal_busy), 0);
        check("rst_done", 32'(cal_done), 0);
        check("rst_alarm", 32'(alarm), 0);

        // 2a: sweep where win_sel>=10 is always erroring -> best 9
        rst = 1'b0;
        cyc(1'b0);
        cal_start = 1'b1;
        cyc(1'b0);
        cal_start = 1'b0;
        check("cal_busy_rise", 32'(cal_busy), 1);
        check("cal_win0", 32'(win_sel), 0);
        done_cnt  = 0;
        done_at   = -1;
        busy_fall = -1;
        for (int i = 1; i <= 340; i++) begin
            cal_start = (i == 100);
            cyc(win_sel >= 4'd10);
            if (cal_done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (!cal_busy && busy_fall < 0) busy_fall = i;
        end
        cal_start = 1'b0;
        check("cal_done_pulses", 32'(done_cnt), 1);
        check("cal_done_time", 32'(done_at), 336);
        check("cal_busy_fall", 32'(busy_fall), 336);
        check("cal_result", 32'(win_sel), 9);
        check("cal_errcnt", 32'(err_cnt), 16);
        check("cal_alarm0", 32'(alarm), 0);
        check("cal_sync_kept", 32'(sync_sel), 1);

        // 2b: every setting noisy -> win_sel 0, alarm
        cal_start = 1'b1;
        cyc(1'b1);
        cal_start = 1'b0;
        repeat (336) cyc(1'b1);
        check("cal2_done", 32'(cal_done), 1);
        check("cal2_win", 32'(win_sel), 0);
        check("cal2_alarm", 32'(alarm), 1);
        check("cal2_busy", 32'(cal_busy), 0);
        cyc(1'b0);
        check("cal2_done_pulse", 32'(cal_done), 0);

        // 3: 5 errors in a window, then blanked errors during SETTLE
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        check("rst_clr_alarm", 32'(alarm), 0);
        en = 1'b1;
        cyc(1'b0);
        for (int t = 0; t <= 19; t++) cyc((t >= 8 && t <= 12) || t >= 20);
        check("w1_pre_sync", 32'(sync_sel), 1);
        cyc(1'b1);
        check("w1_errcnt", 32'(err_cnt), 5);
        check("w1_sync", 32'(sync_sel), 2);
        for (int t = 21; t <= 41; t++) cyc(t <= 23);
        check("blank_errcnt", 32'(err_cnt), 0);
        check("blank_sync", 32'(sync_sel), 2);

        // 4: constant errors -> climb to 7, then alarm
        guard = 0;
        while (!alarm && guard < 400) begin
            cyc(1'b1);
            guard++;
        end
        check("alarm_set", 32'(alarm), 1);
        check("alarm_time", 32'(guard), 122);
        check("max_sync", 32'(sync_sel), 7);
        check("max_errcnt", 32'(err_cnt), 16);
        repeat (50) cyc(1'b0);
        check("alarm_sticky", 32'(alarm), 1);
        check("sync_hold7", 32'(sync_sel), 7);

        // 5: reach sync_sel 3, then quiet windows step down to SYNC_MIN
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        guard = 0;
        while (sync_sel != 3'd3 && guard < 200) begin
            cyc(1'b1);
            guard++;
        end
        check("reach3_time", 32'(guard), 43);
        for (int i = 1; i <= 250; i++) begin
            cyc(1'b0);
            if (i == 71)  check("q_hold3", 32'(sync_sel), 3);
            if (i == 72)  check("q_dec2", 32'(sync_sel), 2);
            if (i == 143) check("q_hold2", 32'(sync_sel), 2);
            if (i == 144) check("q_dec1", 32'(sync_sel), 1);
        end
        check("q_floor", 32'(sync_sel), 1);
        check("q_errcnt", 32'(err_cnt), 0);

        // 6a: reset during CAL_OBS
        en = 1'b0;
        cal_start = 1'b1;
        cyc(1'b0);
        cal_start = 1'b0;
        repeat (10) cyc(1'b1);
        check("obs_busy", 32'(cal_busy), 1);
        rst = 1'b1;
        cyc(1'b1);
        rst = 1'b0;
        check("mid_rst_win", 32'(win_sel), 8);
        check("mid_rst_busy", 32'(cal_busy), 0);
        check("mid_rst_sync", 32'(sync_sel), 1);
        check("mid_rst_errcnt", 32'(err_cnt), 0);

        // 6b: en dropped mid-MONITOR -> IDLE, outputs hold
        en = 1'b1;
        repeat (12) cyc(1'b1);
        en = 1'b0;
        cyc(1'b1);
        repeat (60) cyc(1'b1);
        check("idle_sync", 32'(sync_sel), 1);
        check("idle_errcnt", 32'(err_cnt), 0);
        check("idle_alarm", 32'(alarm), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
